// File: rtl/cl_dmem_port_if.sv
// Core/memory bus bundle for the data-memory port sequencer.
// The slave view is the sequencer; the master view is the core plus memory environment.
interface cl_dmem_port_if;
  logic        req_v_i;
  logic        is_store_i;
  logic        is_byte_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mem_v_o;
  logic        mem_we_o;
  logic [29:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_yumi_i;
  logic        mem_rsp_v_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_v_i, is_store_i, is_byte_i, addr_i, wdata_i,
    input  mem_yumi_i, mem_rsp_v_i, mem_rdata_i,
    output stall_o, done_o, rdata_o, err_o,
    output mem_v_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );

  modport master (
    output req_v_i, is_store_i, is_byte_i, addr_i, wdata_i,
    output mem_yumi_i, mem_rsp_v_i, mem_rdata_i,
    input  stall_o, done_o, rdata_o, err_o,
    input  mem_v_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );
endinterface

// File: rtl/cl_dmem_port.sv
// Data-memory port sequencer: one load/store at a time over a valid/yumi memory bus,
// with byte-lane formatting, misalignment rejection and a load response timeout.
//
// state    | meaning
// IDLE     | waiting for req_v_i; captures the op
// REQ      | mem_v_o held until mem_yumi_i
// WAIT_RSP | load accepted, waiting for mem_rsp_v_i or timeout
// ERR      | one-cycle error completion, no memory access
module cl_dmem_port #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  cl_dmem_port_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, ERR} state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_byte_q;
  logic [31:0] addr_q, wdata_q;
  logic [7:0]  cnt_q;

  logic        misaligned, timeout;
  logic [7:0]  lane;

  logic        done, err, mem_v, mem_we;
  logic [31:0] rdata, mem_wdata;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;

  assign misaligned = ~bus.is_byte_i & (bus.addr_i[1:0] != 2'b00);
  // The counter is cleared on yumi, so TIMEOUT_CYCLES-1 lands the abort exactly TIMEOUT_CYCLES after it.
  assign timeout    = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.req_v_i) state_d = misaligned ? ERR : REQ;
      REQ:      if (bus.mem_yumi_i) state_d = is_store_q ? IDLE : WAIT_RSP;
      WAIT_RSP: if (bus.mem_rsp_v_i || timeout) state_d = IDLE;
      ERR:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_store_q <= 1'b0;
      is_byte_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      if (state_q == IDLE && bus.req_v_i) begin
        is_store_q <= bus.is_store_i;
        is_byte_q  <= bus.is_byte_i;
        addr_q     <= bus.addr_i;
        wdata_q    <= bus.wdata_i;
      end
      if (state_q == REQ)           cnt_q <= '0;
      else if (state_q == WAIT_RSP) cnt_q <= cnt_q + 8'd1;
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane = bus.mem_rdata_i[7:0];
      2'd1:    lane = bus.mem_rdata_i[15:8];
      2'd2:    lane = bus.mem_rdata_i[23:16];
      default: lane = bus.mem_rdata_i[31:24];
    endcase
  end

  always_comb begin
    done      = 1'b0;
    err       = 1'b0;
    rdata     = '0;
    mem_v     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state_q)
      REQ: begin
        mem_v     = 1'b1;
        mem_we    = is_store_q;
        mem_addr  = addr_q[31:2];
        mem_be    = (is_store_q && is_byte_q) ? (4'b0001 << addr_q[1:0]) : 4'b1111;
        mem_wdata = is_byte_q ? {4{wdata_q[7:0]}} : wdata_q;
        done      = bus.mem_yumi_i & is_store_q;
      end
      WAIT_RSP: begin
        if (bus.mem_rsp_v_i) begin
          done  = 1'b1;
          rdata = is_byte_q ? {24'b0, lane} : bus.mem_rdata_i;
        end else if (timeout) begin
          done = 1'b1;
          err  = 1'b1;
        end
      end
      ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.done_o      = done;
  assign bus.err_o       = err;
  assign bus.rdata_o     = rdata;
  assign bus.stall_o     = bus.req_v_i & ~done;
  assign bus.mem_v_o     = mem_v;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_be_o    = mem_be;
  assign bus.mem_wdata_o = mem_wdata;

endmodule

// File: tb/tb_cl_dmem_port.sv
// Directed self-checking bench for cl_dmem_port (TIMEOUT_CYCLES=4).
module tb_cl_dmem_port;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;

  cl_dmem_port_if bif();

  cl_dmem_port #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.req_v_i     = 1'b0;
    bif.is_store_i  = 1'b0;
    bif.is_byte_i   = 1'b0;
    bif.addr_i      = '0;
    bif.wdata_i     = '0;
    bif.mem_yumi_i  = 1'b0;
    bif.mem_rsp_v_i = 1'b0;
    bif.mem_rdata_i = '0;
  endtask

  task automatic op(input logic st, input logic by, input logic [31:0] a, input logic [31:0] d);
    bif.req_v_i    = 1'b1;
    bif.is_store_i = st;
    bif.is_byte_i  = by;
    bif.addr_i     = a;
    bif.wdata_i    = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #12;
    total++; if ({bif.done_o, bif.err_o, bif.mem_v_o, bif.stall_o} !== 4'b0000) $display("FAIL reset_ctl: got %b want 0000", {bif.done_o, bif.err_o, bif.mem_v_o, bif.stall_o}); else passed++;
    total++; if ({bif.rdata_o, bif.mem_be_o, bif.mem_addr_o} !== 66'd0) $display("FAIL reset_data: got rdata=%h be=%b addr=%h want zeros", bif.rdata_o, bif.mem_be_o, bif.mem_addr_o); else passed++;
    bif.req_v_i = 1'b1;
    #1;
    total++; if (bif.stall_o !== 1'b1) $display("FAIL reset_stall_follows_req: got %b want 1", bif.stall_o); else passed++;
    bif.req_v_i = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_sw();
    tick();
    op(1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
    #1;
    total++; if ({bif.stall_o, bif.mem_v_o} !== 2'b10) $display("FAIL sw_idle: got stall,mem_v=%b want 10", {bif.stall_o, bif.mem_v_o}); else passed++;
    tick();
    total++; if ({bif.mem_v_o, bif.mem_we_o, bif.mem_be_o, bif.done_o, bif.stall_o} !== 8'b11_1111_01) $display("FAIL sw_req: got v,we,be,done,stall=%b want 11111101", {bif.mem_v_o, bif.mem_we_o, bif.mem_be_o, bif.done_o, bif.stall_o}); else passed++;
    total++; if ({bif.mem_addr_o, bif.mem_wdata_o} !== {30'h40, 32'hDEADBEEF}) $display("FAIL sw_addr_data: got addr=%h wdata=%h want 40 deadbeef", bif.mem_addr_o, bif.mem_wdata_o); else passed++;
    tick();
    total++; if ({bif.mem_v_o, bif.done_o, bif.stall_o} !== 3'b101) $display("FAIL sw_hold: got v,done,stall=%b want 101", {bif.mem_v_o, bif.done_o, bif.stall_o}); else passed++;
    tick();
    bif.mem_yumi_i = 1'b1;
    #1;
    total++; if ({bif.done_o, bif.err_o, bif.stall_o} !== 3'b100) $display("FAIL sw_done: got done,err,stall=%b want 100", {bif.done_o, bif.err_o, bif.stall_o}); else passed++;
    tick();
    idle_inputs();
    #1;
    total++; if ({bif.done_o, bif.mem_v_o} !== 2'b00) $display("FAIL sw_after: got done,mem_v=%b want 00", {bif.done_o, bif.mem_v_o}); else passed++;
  endtask

  task automatic test_lbu();
    tick();
    op(1'b0, 1'b1, 32'h103, 32'h0);
    tick();
    total++; if ({bif.mem_v_o, bif.mem_we_o, bif.mem_be_o} !== 6'b10_1111 || bif.mem_addr_o !== 30'h40) $display("FAIL lbu_req: got v,we,be=%b addr=%h want 101111 40", {bif.mem_v_o, bif.mem_we_o, bif.mem_be_o}, bif.mem_addr_o); else passed++;
    bif.mem_yumi_i = 1'b1;
    #1;
    total++; if (bif.done_o !== 1'b0) $display("FAIL lbu_no_done_on_yumi: got %b want 0", bif.done_o); else passed++;
    tick();
    bif.mem_yumi_i = 1'b0;
    #1;
    total++; if ({bif.mem_v_o, bif.stall_o, bif.done_o} !== 3'b010) $display("FAIL lbu_wait: got v,stall,done=%b want 010", {bif.mem_v_o, bif.stall_o, bif.done_o}); else passed++;
    tick();
    tick();
    bif.mem_rsp_v_i = 1'b1;
    bif.mem_rdata_i = 32'hAABBCCDD;
    #1;
    total++; if ({bif.done_o, bif.err_o, bif.stall_o} !== 3'b100 || bif.rdata_o !== 32'h000000AA) $display("FAIL lbu_rsp: got done,err,stall=%b rdata=%h want 100 000000aa", {bif.done_o, bif.err_o, bif.stall_o}, bif.rdata_o); else passed++;
    tick();
    idle_inputs();
    #1;
    total++; if ({bif.done_o, bif.rdata_o} !== 33'd0) $display("FAIL lbu_after: got done=%b rdata=%h want 0 0", bif.done_o, bif.rdata_o); else passed++;
  endtask

  task automatic test_sb();
    int nreq = 0;
    tick();
    op(1'b1, 1'b1, 32'h102, 32'h12345678);
    tick();
    if (bif.mem_v_o) nreq++;
    total++; if ({bif.mem_we_o, bif.mem_be_o} !== 5'b1_0100 || bif.mem_wdata_o !== 32'h78787878) $display("FAIL sb_req: got we,be=%b wdata=%h want 10100 78787878", {bif.mem_we_o, bif.mem_be_o}, bif.mem_wdata_o); else passed++;
    bif.mem_yumi_i = 1'b1;
    #1;
    total++; if (bif.done_o !== 1'b1) $display("FAIL sb_done: got %b want 1", bif.done_o); else passed++;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bif.mem_v_o) nreq++;
      tick();
    end
    total++; if (nreq !== 1) $display("FAIL sb_single_req: got %0d requests want 1", nreq); else passed++;
  endtask

  task automatic test_misaligned();
    tick();
    op(1'b0, 1'b0, 32'h105, 32'h0);
    bif.mem_yumi_i = 1'b1;
    #1;
    total++; if ({bif.done_o, bif.mem_v_o} !== 2'b00) $display("FAIL mis_req_cycle: got done,mem_v=%b want 00", {bif.done_o, bif.mem_v_o}); else passed++;
    tick();
    total++; if ({bif.done_o, bif.err_o, bif.mem_v_o} !== 3'b110 || bif.rdata_o !== 32'h0) $display("FAIL mis_err: got done,err,mem_v=%b rdata=%h want 110 0", {bif.done_o, bif.err_o, bif.mem_v_o}, bif.rdata_o); else passed++;
    tick();
    idle_inputs();
    #1;
    total++; if ({bif.done_o, bif.err_o, bif.mem_v_o} !== 3'b000) $display("FAIL mis_after: got %b want 000", {bif.done_o, bif.err_o, bif.mem_v_o}); else passed++;
  endtask

  // rsp_on_last=1 drives the response on the cycle the timeout would fire.
  task automatic test_timeout(input logic rsp_on_last);
    logic [2:0] got;
    tick();
    op(1'b0, 1'b0, 32'h200, 32'h0);
    tick();
    bif.mem_yumi_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      bif.mem_yumi_i = 1'b0;
      if (k == 4 && rsp_on_last) begin
        bif.mem_rsp_v_i = 1'b1;
        bif.mem_rdata_i = 32'h5A5A1234;
      end
      #1;
      got = {bif.done_o, bif.err_o, bif.mem_v_o};
      if (k < 4) begin
        total++; if (got !== 3'b000) $display("FAIL to_early_k%0d: got done,err,v=%b want 000", k, got); else passed++;
      end else if (rsp_on_last) begin
        total++; if (got !== 3'b100 || bif.rdata_o !== 32'h5A5A1234) $display("FAIL to_rsp_wins: got done,err,v=%b rdata=%h want 100 5a5a1234", got, bif.rdata_o); else passed++;
      end else begin
        total++; if (got !== 3'b110 || bif.rdata_o !== 32'h0) $display("FAIL to_abort: got done,err,v=%b rdata=%h want 110 0", got, bif.rdata_o); else passed++;
      end
    end
    tick();
    idle_inputs();
    if (!rsp_on_last) begin
      tick();
      bif.mem_rsp_v_i = 1'b1;
      bif.mem_rdata_i = 32'hFFFFFFFF;
      #1;
      total++; if ({bif.done_o, bif.err_o, bif.mem_v_o} !== 3'b000 || bif.rdata_o !== 32'h0) $display("FAIL to_late_rsp: got done,err,v=%b rdata=%h want 000 0", {bif.done_o, bif.err_o, bif.mem_v_o}, bif.rdata_o); else passed++;
      tick();
      bif.mem_rsp_v_i = 1'b0;
      tick();
      op(1'b1, 1'b0, 32'h8, 32'h1);
      tick();
      total++; if (bif.mem_v_o !== 1'b1) $display("FAIL to_idle_after_late: got mem_v=%b want 1 (op accepted from IDLE)", bif.mem_v_o); else passed++;
      bif.mem_yumi_i = 1'b1;
      tick();
      idle_inputs();
    end
  endtask

  task automatic test_back_to_back();
    int  ndone = 0;
    logic prev_done = 1'b0;
    tick();
    op(1'b0, 1'b0, 32'h300, 32'h0);
    tick();
    bif.mem_yumi_i = 1'b1;
    tick();
    bif.mem_yumi_i = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++; if ({bif.mem_v_o, bif.done_o, bif.err_o} !== 3'b000 || bif.rdata_o !== 32'h0) $display("FAIL rst_mid: got v,done,err=%b rdata=%h want 000 0", {bif.mem_v_o, bif.done_o, bif.err_o}, bif.rdata_o); else passed++;
    op(1'b1, 1'b0, 32'h10, 32'hA5A5A5A5);
    bif.mem_yumi_i  = 1'b1;
    bif.mem_rsp_v_i = 1'b1;
    bif.mem_rdata_i = 32'hCAFEF00D;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 20 && ndone < 2; c++) begin
      tick();
      if (bif.done_o) begin
        total++; if (prev_done) $display("FAIL b2b_adjacent: got done in consecutive cycles want separated"); else passed++;
        ndone++;
        if (ndone == 1) begin
          total++; if (bif.err_o !== 1'b0 || bif.mem_we_o !== 1'b1) $display("FAIL b2b_sw: got err=%b we=%b want 0 1", bif.err_o, bif.mem_we_o); else passed++;
          op(1'b0, 1'b0, 32'h20, 32'h0);
        end else begin
          total++; if (bif.err_o !== 1'b0 || bif.rdata_o !== 32'hCAFEF00D) $display("FAIL b2b_lw: got err=%b rdata=%h want 0 cafef00d", bif.err_o, bif.rdata_o); else passed++;
        end
      end
      prev_done = bif.done_o;
    end
    total++; if (ndone !== 2) $display("FAIL b2b_count: got %0d completions want 2 within 20 cycles", ndone); else passed++;
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lbu();
    test_sb();
    test_misaligned();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
